// File: rtl/regfile_wb_arbiter_pkg.sv
// spu_wb_pkg: shared types and helpers for the register-file write-back arbiter.
//   wb_req_t  - one buffered write-back request (rt / data / issue-order tag)
//   src_t     - request source (even or odd execution pipe)
//   seq_older - wrap-aware issue-order comparison on a configurable tag width
package spu_wb_pkg;

    localparam int unsigned RF_ADDR_W = 7;
    localparam int unsigned RF_DATA_W = 128;
    // Storage width of the sequence tag inside wb_req_t. The arbiter's SEQ_W
    // parameter selects how many low bits take part in the age comparison
    // and must not exceed this value.
    localparam int unsigned SEQ_MAX_W = 16;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rt;
        logic [RF_DATA_W-1:0] data;
        logic [SEQ_MAX_W-1:0] seq;
    } wb_req_t;

    typedef enum logic {
        SRC_EVEN = 1'b0,
        SRC_ODD  = 1'b1
    } src_t;

    // True when tag a was issued before tag b, i.e. (a - b) taken as a
    // signed seq_w-bit quantity is negative. The shift moves bit seq_w-1 of
    // the difference to the MSB, discarding everything above the tag width.
    function automatic logic seq_older(input logic [SEQ_MAX_W-1:0] a,
                                       input logic [SEQ_MAX_W-1:0] b,
                                       input int unsigned          seq_w);
        logic [SEQ_MAX_W-1:0] diff;
        diff = (a - b) << (SEQ_MAX_W - seq_w);
        return diff[SEQ_MAX_W-1];
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: write-back request bus from the two execution pipes
// plus the shared register-file write port toward decode.
//   ev_* / od_*   - per-pipe request (valid, rt, data, seq) and ready
//   registerRT    - register-file write address
//   writeData     - register-file write data
//   regWriteEnable- register-file write strobe
// Modports: master = pipes / register file side, slave = arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned SEQ_W = 6
);
    logic                             ev_valid;
    logic [spu_wb_pkg::RF_ADDR_W-1:0] ev_rt;
    logic [spu_wb_pkg::RF_DATA_W-1:0] ev_data;
    logic [SEQ_W-1:0]                 ev_seq;
    logic                             ev_ready;

    logic                             od_valid;
    logic [spu_wb_pkg::RF_ADDR_W-1:0] od_rt;
    logic [spu_wb_pkg::RF_DATA_W-1:0] od_data;
    logic [SEQ_W-1:0]                 od_seq;
    logic                             od_ready;

    logic [spu_wb_pkg::RF_ADDR_W-1:0] registerRT;
    logic [spu_wb_pkg::RF_DATA_W-1:0] writeData;
    logic                             regWriteEnable;

    modport master (
        output ev_valid, ev_rt, ev_data, ev_seq,
        output od_valid, od_rt, od_data, od_seq,
        input  ev_ready, od_ready,
        input  registerRT, writeData, regWriteEnable
    );

    modport slave (
        input  ev_valid, ev_rt, ev_data, ev_seq,
        input  od_valid, od_rt, od_data, od_seq,
        output ev_ready, od_ready,
        output registerRT, writeData, regWriteEnable
    );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO of wb_req_t with asynchronous reset.
//   clk, reset          - clock, async active-high reset (clears pointers)
//   push, push_data     - write request; ignored while full, even on a pop
//   pop                 - remove head; ignored while empty
//   head                - current oldest entry (valid when !empty)
//   full, empty         - occupancy flags
//   entries, ent_valid  - full storage view, only with WB_PENDING_CHECK_EN
module wb_fifo
    import spu_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
`ifdef WB_PENDING_CHECK_EN
    ,
    output wb_req_t           entries [DEPTH],
    output logic [DEPTH-1:0]  ent_valid
`endif
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

`ifdef WB_PENDING_CHECK_EN
    assign entries = mem;

    // Slot i is live when its distance from the read pointer is below count.
    always_comb begin
        ent_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_valid[i] = ({1'b0, AW'(i) - rd_ptr} < count);
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the decode-stage register-file write port between
// the even and odd execution pipes. Each pipe feeds a private wb_fifo; one
// head is drained per cycle onto registered write-port outputs. Arbitration
// is round-robin between differing destinations; when both heads target the
// same register the older issue-order tag wins and the round-robin pointer
// is left alone.
//   clk, reset     - clock, asynchronous active-high reset
//   bus            - regfile_wb_arbiter_if.slave (pipe requests, write port)
//   conflict_cnt   - saturating count of same-RT head conflicts
//   idle           - both FIFOs empty and no write in flight
// Optional (macro WB_PENDING_CHECK_EN):
//   chk_ra/rb/rc   - decode source registers to probe
//   pend_ra/rb/rc  - a buffered or in-flight write targets that register
module regfile_wb_arbiter
    import spu_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned SEQ_W = 6,   // must be <= SEQ_MAX_W
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]     conflict_cnt,
    output logic                 idle
`ifdef WB_PENDING_CHECK_EN
    ,
    input  logic [RF_ADDR_W-1:0] chk_ra,
    input  logic [RF_ADDR_W-1:0] chk_rb,
    input  logic [RF_ADDR_W-1:0] chk_rc,
    output logic                 pend_ra,
    output logic                 pend_rb,
    output logic                 pend_rc
`endif
);
    wb_req_t ev_req, od_req;
    wb_req_t ev_head, od_head;
    logic    ev_full, ev_empty, od_full, od_empty;
    logic    ev_pop, od_pop;

    src_t    rr_ptr, rr_next;
    logic    grant_v;
    src_t    grant_src;
    logic    conflict;
    wb_req_t win;

    logic [RF_ADDR_W-1:0] wr_rt;
    logic [RF_DATA_W-1:0] wr_data;
    logic                 wr_en;

`ifdef WB_PENDING_CHECK_EN
    wb_req_t          ev_ent [DEPTH];
    wb_req_t          od_ent [DEPTH];
    logic [DEPTH-1:0] ev_vld;
    logic [DEPTH-1:0] od_vld;
`endif

    assign ev_req = '{rt: bus.ev_rt, data: bus.ev_data, seq: SEQ_MAX_W'(bus.ev_seq)};
    assign od_req = '{rt: bus.od_rt, data: bus.od_data, seq: SEQ_MAX_W'(bus.od_seq)};

    wb_fifo #(.DEPTH(DEPTH)) u_ev_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.ev_valid),
        .push_data (ev_req),
        .pop       (ev_pop),
        .head      (ev_head),
        .full      (ev_full),
        .empty     (ev_empty)
`ifdef WB_PENDING_CHECK_EN
        ,
        .entries   (ev_ent),
        .ent_valid (ev_vld)
`endif
    );

    wb_fifo #(.DEPTH(DEPTH)) u_od_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.od_valid),
        .push_data (od_req),
        .pop       (od_pop),
        .head      (od_head),
        .full      (od_full),
        .empty     (od_empty)
`ifdef WB_PENDING_CHECK_EN
        ,
        .entries   (od_ent),
        .ent_valid (od_vld)
`endif
    );

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_ptr <= SRC_EVEN;
        else       rr_ptr <= rr_next;
    end

    // Grant selection and next pointer.
    always_comb begin
        grant_v   = 1'b0;
        grant_src = SRC_EVEN;
        rr_next   = rr_ptr;
        conflict  = 1'b0;
        if (!ev_empty && !od_empty) begin
            grant_v = 1'b1;
            if (ev_head.rt == od_head.rt) begin
                // Age wins on a shared destination; equal tags favour EVEN.
                conflict  = 1'b1;
                grant_src = seq_older(od_head.seq, ev_head.seq, SEQ_W) ? SRC_ODD : SRC_EVEN;
            end else begin
                grant_src = rr_ptr;
                rr_next   = (rr_ptr == SRC_EVEN) ? SRC_ODD : SRC_EVEN;
            end
        end else if (!ev_empty) begin
            grant_v   = 1'b1;
            grant_src = SRC_EVEN;
        end else if (!od_empty) begin
            grant_v   = 1'b1;
            grant_src = SRC_ODD;
        end
    end

    // Pop strobes and winning head.
    always_comb begin
        ev_pop = grant_v && (grant_src == SRC_EVEN);
        od_pop = grant_v && (grant_src == SRC_ODD);
        win    = (grant_src == SRC_ODD) ? od_head : ev_head;
    end

    // Registered write port; address and data hold when nothing is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en        <= 1'b0;
            wr_rt        <= '0;
            wr_data      <= '0;
            conflict_cnt <= '0;
        end else begin
            wr_en <= grant_v;
            if (grant_v) begin
                wr_rt   <= win.rt;
                wr_data <= win.data;
            end
            if (conflict && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.registerRT     = wr_rt;
    assign bus.writeData      = wr_data;
    assign bus.regWriteEnable = wr_en;
    assign bus.ev_ready       = !ev_full;
    assign bus.od_ready       = !od_full;
    assign idle               = ev_empty && od_empty && !wr_en;

`ifdef WB_PENDING_CHECK_EN
    logic [RF_ADDR_W-1:0] chk [3];
    logic [2:0]           pend;

    assign chk = '{chk_ra, chk_rb, chk_rc};

    always_comb begin
        pend = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            if (wr_en && (wr_rt == chk[c])) pend[c] = 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ev_vld[i] && (ev_ent[i].rt == chk[c])) pend[c] = 1'b1;
                if (od_vld[i] && (od_ent[i].rt == chk[c])) pend[c] = 1'b1;
            end
        end
    end

    assign pend_ra = pend[0];
    assign pend_rb = pend[1];
    assign pend_rc = pend[2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] cc;
    logic        idle;
    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned cyc;
    logic        mon_en;
    logic [6:0]  wq_rt [$];
    int unsigned wq_cyc [$];
    logic        seen_low [2];

`ifdef WB_PENDING_CHECK_EN
    logic [6:0] chk_ra, chk_rb, chk_rc;
    logic       pend_ra, pend_rb, pend_rc;
`endif

    regfile_wb_arbiter_if #(.SEQ_W(6)) bus ();

    regfile_wb_arbiter #(.DEPTH(2), .SEQ_W(6), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .conflict_cnt (cc),
        .idle         (idle)
`ifdef WB_PENDING_CHECK_EN
        ,
        .chk_ra       (chk_ra),
        .chk_rb       (chk_rb),
        .chk_rc       (chk_rc),
        .pend_ra      (pend_ra),
        .pend_rb      (pend_rb),
        .pend_rc      (pend_rc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && bus.regWriteEnable) begin
            wq_rt.push_back(bus.registerRT);
            wq_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ev_v;
        logic [6:0]  ev_rt;
        logic [5:0]  ev_seq;
        logic        od_v;
        logic [6:0]  od_rt;
        logic [5:0]  od_seq;
        int unsigned n_wr;
        logic [6:0]  rt0;
        logic        src0;
        logic [6:0]  rt1;
        logic [15:0] exp_cc;
    } vec_t;

    function automatic vec_t mk(input logic ev_v, input logic [6:0] ev_rt, input logic [5:0] ev_seq,
                                input logic od_v, input logic [6:0] od_rt, input logic [5:0] od_seq,
                                input int unsigned n_wr, input logic [6:0] rt0, input logic src0,
                                input logic [6:0] rt1, input logic [15:0] exp_cc);
        vec_t v;
        v.ev_v = ev_v; v.ev_rt = ev_rt; v.ev_seq = ev_seq;
        v.od_v = od_v; v.od_rt = od_rt; v.od_seq = od_seq;
        v.n_wr = n_wr; v.rt0 = rt0; v.src0 = src0; v.rt1 = rt1; v.exp_cc = exp_cc;
        return v;
    endfunction

    // Source 0 = even pipe (A5 pattern), source 1 = odd pipe (5A pattern).
    function automatic logic [127:0] data_of(input logic src, input logic [6:0] rt);
        logic [119:0] pat;
        pat = src ? {15{8'h5A}} : {15{8'hA5}};
        return {pat, 1'b0, rt};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int unsigned guard;
        guard = 0;
        while (!idle && guard < 60) begin
            step();
            guard++;
        end
        check(nm, 128'(idle), 128'(1'b1));
    endtask

    // Pushes n entries from one source, honouring ready; ready is sampled
    // just after an edge and stays stable until the next one.
    task automatic drive_src(input logic src, input logic [6:0] r0, input logic [6:0] r1,
                             input logic [6:0] r2, input logic [6:0] r3, input int unsigned n);
        logic [6:0]  rts [4];
        logic        rdy;
        int unsigned guard;
        rts = '{r0, r1, r2, r3};
        for (int unsigned k = 0; k < n; k++) begin
            if (src) begin
                bus.od_valid = 1'b1; bus.od_rt = rts[k];
                bus.od_data = data_of(1'b1, rts[k]); bus.od_seq = 6'(k);
            end else begin
                bus.ev_valid = 1'b1; bus.ev_rt = rts[k];
                bus.ev_data = data_of(1'b0, rts[k]); bus.ev_seq = 6'(k);
            end
            guard = 0;
            do begin
                rdy = src ? bus.od_ready : bus.ev_ready;
                if (!rdy) seen_low[src] = 1'b1;
                step();
                guard++;
            end while (!rdy && guard < 50);
            check("push_accept_timeout", 128'(rdy), 128'(1'b1));
        end
        if (src) bus.od_valid = 1'b0;
        else     bus.ev_valid = 1'b0;
    endtask

    vec_t        vecs [8];
    logic [6:0]  exp_stream [6];
    logic [6:0]  ev_got [$];
    logic [6:0]  od_got [$];

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; mon_en = 1'b0;
        seen_low[0] = 1'b0; seen_low[1] = 1'b0;
        bus.ev_valid = 1'b0; bus.ev_rt = '0; bus.ev_data = '0; bus.ev_seq = '0;
        bus.od_valid = 1'b0; bus.od_rt = '0; bus.od_data = '0; bus.od_seq = '0;
`ifdef WB_PENDING_CHECK_EN
        chk_ra = '0; chk_rb = 7'd127; chk_rc = 7'd126;
`endif
        //          ev  rt   seq   od  rt   seq  n  rt0 src0  rt1 cc
        vecs[0] = mk(1, 5,   1,    0,  0,   0,   1, 5,  0,    0,  0);
        vecs[1] = mk(0, 0,   0,    1,  9,   2,   1, 9,  1,    0,  0);
        vecs[2] = mk(1, 7,   5,    1,  7,   4,   2, 7,  1,    7,  1);
        vecs[3] = mk(1, 3,   6,    1,  4,   7,   2, 3,  0,    4,  1);
        vecs[4] = mk(1, 20,  62,   1,  20,  1,   2, 20, 0,    20, 2);
        vecs[5] = mk(1, 30,  8,    1,  31,  9,   2, 31, 1,    30, 2);
        vecs[6] = mk(1, 40,  8,    1,  40,  8,   2, 40, 0,    40, 3);
        vecs[7] = mk(1, 41,  1,    1,  41,  62,  2, 41, 1,    41, 4);
        exp_stream = '{7'd1, 7'd10, 7'd2, 7'd11, 7'd3, 7'd12};

        // Reset state
        reset = 1'b1;
        #2;
        check("rst_we",    128'(bus.regWriteEnable), 128'(1'b0));
        check("rst_rt",    128'(bus.registerRT),     128'(0));
        check("rst_data",  bus.writeData,            128'(0));
        check("rst_idle",  128'(idle),               128'(1'b1));
        check("rst_evrdy", 128'(bus.ev_ready),       128'(1'b1));
        check("rst_odrdy", 128'(bus.od_ready),       128'(1'b1));
        check("rst_cc",    128'(cc),                 128'(0));
        @(negedge clk);
        reset = 1'b0;
        step();

        // Directed single/paired requests from idle
        for (int unsigned i = 0; i < 8; i++) begin
            bus.ev_valid = vecs[i].ev_v; bus.ev_rt = vecs[i].ev_rt;
            bus.ev_data = data_of(1'b0, vecs[i].ev_rt); bus.ev_seq = vecs[i].ev_seq;
            bus.od_valid = vecs[i].od_v; bus.od_rt = vecs[i].od_rt;
            bus.od_data = data_of(1'b1, vecs[i].od_rt); bus.od_seq = vecs[i].od_seq;
            step();
            bus.ev_valid = 1'b0; bus.od_valid = 1'b0;
            step();
            check($sformatf("v%0d_we0", i),   128'(bus.regWriteEnable), 128'(1'b1));
            check($sformatf("v%0d_rt0", i),   128'(bus.registerRT),     128'(vecs[i].rt0));
            check($sformatf("v%0d_data0", i), bus.writeData,            data_of(vecs[i].src0, vecs[i].rt0));
            step();
            if (vecs[i].n_wr == 2) begin
                check($sformatf("v%0d_we1", i),   128'(bus.regWriteEnable), 128'(1'b1));
                check($sformatf("v%0d_rt1", i),   128'(bus.registerRT),     128'(vecs[i].rt1));
                check($sformatf("v%0d_data1", i), bus.writeData,            data_of(!vecs[i].src0, vecs[i].rt1));
                step();
            end
            check($sformatf("v%0d_we_off", i), 128'(bus.regWriteEnable), 128'(1'b0));
            check($sformatf("v%0d_idle", i),   128'(idle),               128'(1'b1));
            check($sformatf("v%0d_cc", i),     128'(cc),                 128'(vecs[i].exp_cc));
        end

        // Both pipes streaming distinct RTs: alternate from EVEN, no bubbles
        wq_rt.delete(); wq_cyc.delete(); mon_en = 1'b1;
        fork
            drive_src(1'b0, 7'd1,  7'd2,  7'd3,  7'd0, 3);
            drive_src(1'b1, 7'd10, 7'd11, 7'd12, 7'd0, 3);
        join
        wait_idle("stream_idle");
        mon_en = 1'b0;
        check("stream_count", 128'(wq_rt.size()), 128'(6));
        for (int unsigned i = 0; i < 6 && i < wq_rt.size(); i++) begin
            check($sformatf("stream_rt%0d", i), 128'(wq_rt[i]), 128'(exp_stream[i]));
            check($sformatf("stream_cyc%0d", i), 128'(wq_cyc[i] - wq_cyc[0]), 128'(i));
        end
        check("stream_cc", 128'(cc), 128'(4));

        // Backpressure: both push 4 entries, FIFOs fill, nothing lost or duplicated
        wq_rt.delete(); wq_cyc.delete(); mon_en = 1'b1;
        seen_low[0] = 1'b0; seen_low[1] = 1'b0;
        fork
            drive_src(1'b0, 7'd60, 7'd61, 7'd62, 7'd63, 4);
            drive_src(1'b1, 7'd50, 7'd51, 7'd52, 7'd53, 4);
        join
        wait_idle("bp_idle");
        mon_en = 1'b0;
        check("bp_od_ready_low", 128'(seen_low[1]), 128'(1'b1));
        check("bp_count", 128'(wq_rt.size()), 128'(8));
        ev_got.delete(); od_got.delete();
        foreach (wq_rt[i]) begin
            if (wq_rt[i] >= 7'd60) ev_got.push_back(wq_rt[i]);
            else                   od_got.push_back(wq_rt[i]);
        end
        check("bp_ev_count", 128'(ev_got.size()), 128'(4));
        check("bp_od_count", 128'(od_got.size()), 128'(4));
        for (int unsigned i = 0; i < 4 && i < ev_got.size(); i++)
            check($sformatf("bp_ev_order%0d", i), 128'(ev_got[i]), 128'(60 + i));
        for (int unsigned i = 0; i < 4 && i < od_got.size(); i++)
            check($sformatf("bp_od_order%0d", i), 128'(od_got[i]), 128'(50 + i));

        // Reset asserted with three entries buffered
        bus.ev_valid = 1'b1; bus.ev_rt = 7'd70; bus.ev_data = data_of(1'b0, 7'd70); bus.ev_seq = 6'd1;
        bus.od_valid = 1'b1; bus.od_rt = 7'd71; bus.od_data = data_of(1'b1, 7'd71); bus.od_seq = 6'd2;
        step();
        bus.ev_rt = 7'd72; bus.ev_data = data_of(1'b0, 7'd72); bus.ev_seq = 6'd3;
        bus.od_rt = 7'd73; bus.od_data = data_of(1'b1, 7'd73); bus.od_seq = 6'd4;
        step();
        bus.ev_valid = 1'b0; bus.od_valid = 1'b0;
`ifdef WB_PENDING_CHECK_EN
        chk_ra = 7'd73;
        #1;
        check("pend_before_rst", 128'(pend_ra), 128'(1'b1));
`endif
        check("pre_rst_we", 128'(bus.regWriteEnable), 128'(1'b1));
        check("pre_rst_idle", 128'(idle), 128'(1'b0));
        #1;
        reset = 1'b1;
        #1;
        check("arst_we",    128'(bus.regWriteEnable), 128'(1'b0));
        check("arst_rt",    128'(bus.registerRT),     128'(0));
        check("arst_data",  bus.writeData,            128'(0));
        check("arst_idle",  128'(idle),               128'(1'b1));
        check("arst_evrdy", 128'(bus.ev_ready),       128'(1'b1));
        check("arst_odrdy", 128'(bus.od_ready),       128'(1'b1));
        check("arst_cc",    128'(cc),                 128'(0));
`ifdef WB_PENDING_CHECK_EN
        check("pend_after_rst", 128'(pend_ra), 128'(1'b0));
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wq_rt.delete(); wq_cyc.delete(); mon_en = 1'b1;
        repeat (6) step();
        mon_en = 1'b0;
        check("post_rst_writes", 128'(wq_rt.size()), 128'(0));
        check("post_rst_idle",   128'(idle),         128'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
